// File: rtl/lower_layer_sort.sv
// lower_layer_sort
//
// Collects two short sorted runs from a single element stream and presents
// their heads to a downstream merge stage.
//
// The first L_SIZE accepted elements form the left run and the next R_SIZE
// form the right run. Each element is insertion-sorted in one cycle with a
// parallel compare-and-shift. Once both runs are full the block enters DRAIN
// and raises done_lower. The merge stage then pops heads with
// shift_en_L / shift_en_R and releases the runs with done_upper.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid, in_data    upstream element stream
//   in_ready             element accepted this cycle (fill states only)
//   done_lower           registered level: both runs full and sorted
//   shift_en_L/_R        pop the head of the left / right run (DRAIN only)
//   done_upper           merge finished: clear runs, go back to filling
//   head_L/_R            smallest remaining element of each run (0 if empty)
//   empty_L/_R           run has no remaining elements
//   cmp                  1 = left head goes next, 0 = right head goes next
module lower_layer_sort #(
    parameter int L_SIZE = 4,
    parameter int R_SIZE = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              done_lower,
    input  logic              shift_en_L,
    input  logic              shift_en_R,
    input  logic              done_upper,
    output logic [DATA_W-1:0] head_L,
    output logic [DATA_W-1:0] head_R,
    output logic              empty_L,
    output logic              empty_R,
    output logic              cmp
);

    localparam int LCW = $clog2(L_SIZE + 1);
    localparam int RCW = $clog2(R_SIZE + 1);

    typedef enum logic [1:0] {
        FILL_L,
        FILL_R,
        DRAIN
    } state_t;

    state_t            state_reg;
    logic              done_lower_reg;
    logic [LCW-1:0]    cnt_l_reg;
    logic [RCW-1:0]    cnt_r_reg;
    logic [DATA_W-1:0] run_l_reg [L_SIZE];
    logic [DATA_W-1:0] run_r_reg [R_SIZE];

    // Candidate next contents of each run: after an insert of in_data, and
    // after a pop of the head.
    logic [DATA_W-1:0] ins_l_next [L_SIZE];
    logic [DATA_W-1:0] ins_r_next [R_SIZE];
    logic [DATA_W-1:0] pop_l_next [L_SIZE];
    logic [DATA_W-1:0] pop_r_next [R_SIZE];

    // slot_x[i] marks positions at or beyond the insertion point that must
    // change: occupied entries strictly greater than in_data, plus the first
    // free entry. Using '>' (not '>=') keeps equal values ahead of the new
    // element, so insertion is stable. Because the run is sorted, slot_x is
    // a contiguous band; its first bit takes in_data, the rest take their
    // left neighbour.
    logic [L_SIZE-1:0] slot_l;
    logic [R_SIZE-1:0] slot_r;

    logic accept;
    logic pop_l_en;
    logic pop_r_en;

    generate
        for (genvar gi = 0; gi < L_SIZE; gi++) begin : g_left
            assign slot_l[gi] = (LCW'(gi) < cnt_l_reg) ? (run_l_reg[gi] > in_data)
                                                       : (LCW'(gi) == cnt_l_reg);
            if (gi == 0) begin : g_first
                assign ins_l_next[gi] = slot_l[gi] ? in_data : run_l_reg[gi];
            end else begin : g_rest
                assign ins_l_next[gi] = !slot_l[gi]    ? run_l_reg[gi]
                                      : slot_l[gi-1]   ? run_l_reg[gi-1]
                                      :                  in_data;
            end
            if (gi == L_SIZE - 1) begin : g_tail
                assign pop_l_next[gi] = '0;
            end else begin : g_body
                assign pop_l_next[gi] = run_l_reg[gi+1];
            end
        end

        for (genvar gi = 0; gi < R_SIZE; gi++) begin : g_right
            assign slot_r[gi] = (RCW'(gi) < cnt_r_reg) ? (run_r_reg[gi] > in_data)
                                                       : (RCW'(gi) == cnt_r_reg);
            if (gi == 0) begin : g_first
                assign ins_r_next[gi] = slot_r[gi] ? in_data : run_r_reg[gi];
            end else begin : g_rest
                assign ins_r_next[gi] = !slot_r[gi]    ? run_r_reg[gi]
                                      : slot_r[gi-1]   ? run_r_reg[gi-1]
                                      :                  in_data;
            end
            if (gi == R_SIZE - 1) begin : g_tail
                assign pop_r_next[gi] = '0;
            end else begin : g_body
                assign pop_r_next[gi] = run_r_reg[gi+1];
            end
        end
    endgenerate

    // in_ready is forced low during reset so an upstream source never sees
    // a handshake that the block is going to discard.
    assign in_ready = !rst && (state_reg != DRAIN);
    assign accept   = in_valid && in_ready;

    // done_upper wins over pops in the same cycle.
    assign pop_l_en = shift_en_L && !done_upper && (cnt_l_reg != '0);
    assign pop_r_en = shift_en_R && !done_upper && (cnt_r_reg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FILL_L;
            done_lower_reg <= 1'b0;
            cnt_l_reg      <= '0;
            cnt_r_reg      <= '0;
            for (int i = 0; i < L_SIZE; i++) run_l_reg[i] <= '0;
            for (int i = 0; i < R_SIZE; i++) run_r_reg[i] <= '0;
        end else begin
            case (state_reg)
                FILL_L: begin
                    if (accept) begin
                        run_l_reg <= ins_l_next;
                        cnt_l_reg <= cnt_l_reg + LCW'(1);
                        if (cnt_l_reg == LCW'(L_SIZE - 1)) begin
                            state_reg <= FILL_R;
                        end
                    end
                end
                FILL_R: begin
                    // Left run is frozen here; only the right run grows.
                    if (accept) begin
                        run_r_reg <= ins_r_next;
                        cnt_r_reg <= cnt_r_reg + RCW'(1);
                        if (cnt_r_reg == RCW'(R_SIZE - 1)) begin
                            state_reg      <= DRAIN;
                            done_lower_reg <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (done_upper) begin
                        state_reg      <= FILL_L;
                        done_lower_reg <= 1'b0;
                        cnt_l_reg      <= '0;
                        cnt_r_reg      <= '0;
                        for (int i = 0; i < L_SIZE; i++) run_l_reg[i] <= '0;
                        for (int i = 0; i < R_SIZE; i++) run_r_reg[i] <= '0;
                    end else begin
                        if (pop_l_en) begin
                            run_l_reg <= pop_l_next;
                            cnt_l_reg <= cnt_l_reg - LCW'(1);
                        end
                        if (pop_r_en) begin
                            run_r_reg <= pop_r_next;
                            cnt_r_reg <= cnt_r_reg - RCW'(1);
                        end
                    end
                end
                default: begin
                    state_reg      <= FILL_L;
                    done_lower_reg <= 1'b0;
                end
            endcase
        end
    end

    // Head/empty/cmp depend on registered state only, so the merge stage can
    // decide its next pop without a combinational loop through shift_en_*.
    assign done_lower = done_lower_reg;
    assign empty_L    = (cnt_l_reg == '0);
    assign empty_R    = (cnt_r_reg == '0);
    assign head_L     = empty_L ? '0 : run_l_reg[0];
    assign head_R     = empty_R ? '0 : run_r_reg[0];

    always_comb begin
        cmp = 1'b0;
        if (!empty_L && !empty_R) begin
            cmp = (head_L <= head_R);
        end else if (!empty_L) begin
            cmp = 1'b1;
        end
    end

endmodule
